rcv_phy_deframer: RTL

- Receive-side counterpart of the transmit path: takes the 4-bit PHY receive stream, strips the preamble and SFD, and reassembles nibbles into bytes.
- Emits a byte stream plus an end-of-frame control block in the same 24-bit format the transmit path consumes.
- Sits between the PHY receive pins and the receive-side frame buffer, entirely in the clk_phy domain.
- Flags malformed frames (short, long, odd nibble count, bad preamble) and keeps saturating good and bad frame counters.

---
 rtl/rcv_phy_deframer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rcv_phy_deframer.sv
// Receive deframer: strips preamble/SFD from the 4-bit PHY stream, packs nibbles into bytes,
// and reports per-frame byte count and error status with saturating good/bad counters.
module rcv_phy_deframer #(
  parameter int MIN_PRE = 7,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk_phy,
  input  logic        reset,
  input  logic        phy_rx_dv,
  input  logic [3:0]  phy_rx_data,
  output logic [7:0]  r_data_out,
  output logic        r_data_valid,
  output logic        r_sof,
  output logic        r_frame_valid,
  output logic [23:0] r_ctrl_out,
  output logic        r_frame_err,
  output logic [15:0] r_good_cnt,
  output logic [15:0] r_bad_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [3:0]  MIN_PRE_C = 4'(MIN_PRE);
  localparam logic [11:0] MIN_LEN_C = 12'(MIN_LEN);
  localparam logic [11:0] MAX_LEN_C = 12'(MAX_LEN);

  logic [1:0]  state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  lat_q, lat_d;
  logic [11:0] byte_cnt_q, byte_cnt_d;
  logic        long_q, long_d;
  logic [7:0]  data_q, data_d;
  logic        dvld_q, dvld_d;
  logic        sof_q, sof_d;
  logic        fv_q, fv_d;
  logic [23:0] ctrl_q, ctrl_d;
  logic        err_q, err_d;
  logic [15:0] good_q, good_d;
  logic [15:0] bad_q, bad_d;
  logic        frame_bad;

  assign frame_bad = long_q | phase_q | (byte_cnt_q < MIN_LEN_C);

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    phase_d    = phase_q;
    lat_d      = lat_q;
    byte_cnt_d = byte_cnt_q;
    long_d     = long_q;
    data_d     = data_q;
    dvld_d     = 1'b0;
    sof_d      = 1'b0;
    fv_d       = 1'b0;
    ctrl_d     = ctrl_q;
    err_d      = err_q;
    good_d     = good_q;
    bad_d      = bad_q;
    case (state_q)
      S_IDLE: begin
        if (phy_rx_dv) begin
          if (phy_rx_data == 4'h5) begin
            state_d   = S_PRE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_PRE: begin
        if (!phy_rx_dv) begin
          state_d = S_IDLE;
        end else if (phy_rx_data == 4'h5) begin
          pre_cnt_d = (pre_cnt_q == 4'hF) ? pre_cnt_q : pre_cnt_q + 4'd1;
        end else if (phy_rx_data == 4'hD && pre_cnt_q >= MIN_PRE_C) begin
          state_d    = S_DATA;
          phase_d    = 1'b0;
          byte_cnt_d = 12'd0;
          long_d     = 1'b0;
        end else begin
          state_d = S_DROP;
          bad_d   = (bad_q == 16'hFFFF) ? bad_q : bad_q + 16'd1;
        end
      end
      S_DATA: begin
        if (phy_rx_dv) begin
          if (!phase_q) begin
            lat_d   = phy_rx_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            // Bytes past MAX_LEN are swallowed but mark the frame as long.
            if (byte_cnt_q < MAX_LEN_C) begin
              data_d     = {phy_rx_data, lat_q};
              dvld_d     = 1'b1;
              sof_d      = (byte_cnt_q == 12'd0);
              byte_cnt_d = (byte_cnt_q == 12'hFFF) ? byte_cnt_q : byte_cnt_q + 12'd1;
            end else begin
              long_d = 1'b1;
            end
          end
        end else begin
          state_d = S_IDLE;
          fv_d    = 1'b1;
          ctrl_d  = {byte_cnt_q, byte_cnt_q};
          err_d   = frame_bad;
          if (frame_bad) begin
            bad_d = (bad_q == 16'hFFFF) ? bad_q : bad_q + 16'd1;
          end else begin
            good_d = (good_q == 16'hFFFF) ? good_q : good_q + 16'd1;
          end
        end
      end
      default: begin
        if (!phy_rx_dv) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_phy or posedge reset) begin
    if (reset) begin
      state_q    <= S_DROP;
      pre_cnt_q  <= 4'd0;
      phase_q    <= 1'b0;
      lat_q      <= 4'd0;
      byte_cnt_q <= 12'd0;
      long_q     <= 1'b0;
      data_q     <= 8'd0;
      dvld_q     <= 1'b0;
      sof_q      <= 1'b0;
      fv_q       <= 1'b0;
      ctrl_q     <= 24'd0;
      err_q      <= 1'b0;
      good_q     <= 16'd0;
      bad_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      phase_q    <= phase_d;
      lat_q      <= lat_d;
      byte_cnt_q <= byte_cnt_d;
      long_q     <= long_d;
      data_q     <= data_d;
      dvld_q     <= dvld_d;
      sof_q      <= sof_d;
      fv_q       <= fv_d;
      ctrl_q     <= ctrl_d;
      err_q      <= err_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
    end
  end

  assign r_data_out    = data_q;
  assign r_data_valid  = dvld_q;
  assign r_sof         = sof_q;
  assign r_frame_valid = fv_q;
  assign r_ctrl_out    = ctrl_q;
  assign r_frame_err   = err_q;
  assign r_good_cnt    = good_q;
  assign r_bad_cnt     = bad_q;

endmodule
